digit_scan_ctrl: RTL and testbench
==================================

Name: digit_scan_ctrl

Overview:
Time-multiplexed display scanner driving one shared 74HC4511-style BCD-to-7-segment decoder and a bank of common-cathode digits. Sits directly upstream of the decoder. Each frame it snapshots a packed BCD word, steps through the digits and presents each nibble on INn. It also drives the decoder's LE/BI/LT controls and the one-hot digit enables, with a blanking dead-time between digits, optional leading-zero suppression and lamp test.

Parameters:
DIGITS, 8, number of digits scanned (2..16)
DIV, 1000, CLK cycles each digit is lit (>=1)
DEAD, 8, CLK cycles of blanking between digits (>=1)

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  synchronous reset, active-high
EN  input  1  scan enable; 0 = display dark
Data  input  4*DIGITS  packed BCD; Data[3:0] = digit 0 (least significant), Data[4*DIGITS-1 -: 4] = MSD
ZBLANK  input  1  1 = suppress leading zeros
TEST  input  1  1 = lamp test on every scanned digit
INn  output  4  BCD nibble to decoder
LE  output  1  decoder latch enable, active-low (0 = transparent)
BI  output  1  decoder blanking, active-low
LT  output  1  decoder lamp test, active-low
Dig  output  DIGITS  one-hot digit enable, active-high
Frame  output  1  one-cycle pulse at end of each complete frame

Behaviour:
- One clock (CLK); reset synchronous, active-high (RST). All outputs registered.
- Reset values: INn=0, LE=1, BI=0, LT=1, Dig=0, Frame=0; state IDLE, idx=0, counter=0, shadow=0.
- States:
  - IDLE: Dig=0, BI=0, LE=1.
  - DEAD: Dig=0, BI=0, LE=0, INn = shadow nibble[idx].
  - SHOW: Dig=(1<<idx), LE=0, BI per blanking rule below.
- IDLE -> DEAD when EN=1. On that edge: shadow<=Data, idx<=0, counter<=0.
- DEAD: counts DEAD cycles, then -> SHOW with counter<=0.
- SHOW: counts DIV cycles, then:
  - If idx<DIGITS-1: idx<=idx+1, -> DEAD.
  - If idx=DIGITS-1: idx<=0 (wrap), shadow<=Data, Frame=1 for one cycle, -> DEAD.
- Frame period = DIGITS*(DEAD+DIV) cycles. Dig is never nonzero during DEAD. Two Dig bits are never set at once.
- Any state with EN=0 -> IDLE on the next edge: Dig=0, BI=0, LE=1, idx=0, counter=0. No Frame pulse.
- Data changes mid-frame have no effect until the next frame snapshot.
- Leading-zero blanking, computed on shadow: digit k is blanked when ZBLANK=1 and all nibbles k..DIGITS-1 equal 0. Digit 0 is never blanked.
- BI in SHOW = 0 if the digit is blanked, else 1.
- Nibble values 0xA..0xF are passed through unchanged; the decoder renders them.
- LT = ~TEST, registered one cycle; applied in every state except IDLE, where LT=1.
- While TEST=1 in SHOW: BI forced to 1, overriding blanking. Scanning and timing continue unchanged.
- Simultaneous EN fall and frame end: EN wins, no Frame pulse.
- RST overrides everything; RST mid-frame returns all reset values on the next edge.
- Counter width = clog2(max(DIV,DEAD)+1). No overflow: the counter clears on every state change.

Test Plan:
- Reset: DIGITS=4, DIV=4, DEAD=2; hold RST 3 cycles -> INn=0, LE=1, BI=0, LT=1, Dig=0, Frame=0.
- Basic scan: EN=1, Data=16'h4321, ZBLANK=0 -> Dig sequence 0001,0010,0100,1000, each lit 4 cycles with INn=1,2,3,4. Dig=0 and BI=0 for 2 cycles between digits. Frame pulses every 24 cycles.
- Leading zeros: Data=16'h0050, ZBLANK=1 -> BI=0 while Dig=1000 and 0100; BI=1 for digits 1 (INn=5) and 0 (INn=0). With ZBLANK=0, all digits BI=1.
- Snapshot: change Data from 16'h1111 to 16'h2222 while Dig=0010 -> rest of frame shows 1; next frame shows 2.
- Lamp test: TEST=1 with Data=16'h0000, ZBLANK=1 -> one cycle later LT=0; BI=1 on every SHOW digit; scan period unchanged.
- Disable/reset mid-frame: drop EN while Dig=0100 -> next cycle Dig=0, BI=0, LE=1, no Frame pulse. Re-enable -> scan restarts at digit 0 after DEAD cycles. Assert RST mid-SHOW -> reset values next cycle.

Source files
------------

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed scanner for a shared 4511-style BCD
// decoder and a bank of common-cathode digits. Each frame snapshots Data,
// walks the digits with a blanking dead-time between them, and drives the
// decoder LE/BI/LT controls, with optional leading-zero suppression and
// lamp test.
module digit_scan_ctrl #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DIV    = 1000,
  parameter int unsigned DEAD   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic [4*DIGITS-1:0]   Data,
  input  logic                  ZBLANK,
  input  logic                  TEST,
  output logic [3:0]            INn,
  output logic                  LE,
  output logic                  BI,
  output logic                  LT,
  output logic [DIGITS-1:0]     Dig,
  output logic                  Frame
);

  localparam int unsigned MAXC = (DIV > DEAD) ? DIV : DEAD;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned IW   = $clog2(DIGITS);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEAD,
    S_SHOW
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic                  frame_d;

  logic [DIGITS-1:0]     blank;
  logic                  lz;

  logic [3:0]            inn_d;
  logic                  le_d, bi_d, lt_d;
  logic [DIGITS-1:0]     dig_d;

  // Next-state: dead-time / show sequencing, frame wrap and Data snapshot
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    frame_d  = 1'b0;
    if (!EN) begin
      // Disable beats a coincident frame end, so no Frame pulse here
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_DEAD;
          shadow_d = Data;
          idx_d    = '0;
          cnt_d    = '0;
        end
        S_DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (cnt_q == DIV_LAST) begin
            state_d = S_DEAD;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d    = '0;
              shadow_d = Data;
              frame_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Leading-zero mask: digit k blanked when it and every higher nibble are zero
  always_comb begin
    blank = '0;
    lz    = 1'b1;
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      lz = lz & (shadow_d[4*(DIGITS-1-i) +: 4] == 4'h0);
      blank[DIGITS-1-i] = ZBLANK & lz;
    end
  end

  // Output decode from the next state so every output is a plain register
  always_comb begin
    inn_d = INn;
    le_d  = 1'b1;
    bi_d  = 1'b0;
    lt_d  = 1'b1;
    dig_d = '0;
    case (state_d)
      S_DEAD: begin
        le_d  = 1'b0;
        lt_d  = ~TEST;
        inn_d = shadow_d[4*int'(idx_d) +: 4];
      end
      S_SHOW: begin
        le_d         = 1'b0;
        lt_d         = ~TEST;
        inn_d        = shadow_d[4*int'(idx_d) +: 4];
        dig_d[idx_d] = 1'b1;
        bi_d         = TEST | ~blank[idx_d];
      end
      default: ;
    endcase
  end

  // Scan FSM state and registered decoder/digit outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      INn      <= '0;
      LE       <= 1'b1;
      BI       <= 1'b0;
      LT       <= 1'b1;
      Dig      <= '0;
      Frame    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      INn      <= inn_d;
      LE       <= le_d;
      BI       <= bi_d;
      LT       <= lt_d;
      Dig      <= dig_d;
      Frame    <= frame_d;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Bench for digit_scan_ctrl: a frame-position reference model feeds a
// scoreboard every cycle; a table of hand-computed vectors covers the first
// frame, and short sequences cover blanking, snapshot, lamp test, disable
// and reset corners.
module tb_digit_scan_ctrl;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 4;
  localparam int unsigned DEAD   = 2;
  localparam int          SLOT   = DEAD + DIV;
  localparam int          FRAME  = DIGITS * SLOT;

  logic        CLK = 1'b0;
  logic        RST, EN, ZBLANK, TEST;
  logic [15:0] Data;
  logic [3:0]  INn;
  logic        LE, BI, LT, Frame;
  logic [3:0]  Dig;

  always #5 CLK = ~CLK;

  digit_scan_ctrl #(
    .DIGITS(DIGITS),
    .DIV   (DIV),
    .DEAD  (DEAD)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .EN    (EN),
    .Data  (Data),
    .ZBLANK(ZBLANK),
    .TEST  (TEST),
    .INn   (INn),
    .LE    (LE),
    .BI    (BI),
    .LT    (LT),
    .Dig   (Dig),
    .Frame (Frame)
  );

  typedef struct packed {
    logic [3:0] inn;
    logic       le;
    logic       bi;
    logic       lt;
    logic [3:0] dig;
    logic       frame;
  } obs_t;

  typedef struct {
    logic        en;
    logic [15:0] data;
    logic [3:0]  dig;
    logic [3:0]  inn;
    logic        bi;
    logic        frame;
  } vec_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position within the frame, not a state/counter pair
  bit          m_on    = 1'b0;
  int          m_pos   = 0;
  logic [15:0] m_shadow = '0;
  obs_t        m_out   = '0;

  task automatic model_step();
    int d, w;
    if (RST) begin
      m_on = 1'b0; m_pos = 0; m_shadow = '0;
      m_out = '{inn: 4'h0, le: 1'b1, bi: 1'b0, lt: 1'b1, dig: 4'h0, frame: 1'b0};
    end else if (!EN) begin
      m_on = 1'b0; m_pos = 0;
      m_out.dig = 4'h0; m_out.bi = 1'b0; m_out.le = 1'b1;
      m_out.lt = 1'b1; m_out.frame = 1'b0;
    end else begin
      m_out.frame = 1'b0;
      if (!m_on) begin
        m_on = 1'b1; m_pos = 0; m_shadow = Data;
      end else begin
        m_pos++;
        if (m_pos == FRAME) begin
          m_pos = 0; m_shadow = Data; m_out.frame = 1'b1;
        end
      end
      d = m_pos / SLOT;
      w = m_pos % SLOT;
      m_out.inn = 4'(m_shadow >> (4*d));
      m_out.le  = 1'b0;
      m_out.lt  = ~TEST;
      if (w < DEAD) begin
        m_out.dig = 4'h0; m_out.bi = 1'b0;
      end else begin
        m_out.dig = 4'(1 << d);
        m_out.bi  = TEST || !(ZBLANK && d > 0 && (m_shadow >> (4*d)) == 16'h0);
      end
    end
    exp_q.push_back(m_out);
  endtask

  task automatic step();
    obs_t e, a;
    model_step();
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    a = '{inn: INn, le: LE, bi: BI, lt: LT, dig: Dig, frame: Frame};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t actual inn=%h le=%b bi=%b lt=%b dig=%b frame=%b required inn=%h le=%b bi=%b lt=%b dig=%b frame=%b",
               $time, a.inn, a.le, a.bi, a.lt, a.dig, a.frame,
               e.inn, e.le, e.bi, e.lt, e.dig, e.frame);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: actual timeout required event", name);
  endtask

  task automatic step_until_frame(input int maxc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (Frame !== 1'b1 && n < maxc);
    if (Frame !== 1'b1) timeout("frame_wait");
  endtask

  task automatic step_until_dig(input logic [3:0] target, input int maxc);
    int n = 0;
    while (m_out.dig !== target && n < maxc) begin
      step();
      n++;
    end
    if (m_out.dig !== target) timeout("dig_wait");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_INn"},   16'(INn),   16'h0);
    chk({tag, "_LE"},    16'(LE),    16'h1);
    chk({tag, "_BI"},    16'(BI),    16'h0);
    chk({tag, "_LT"},    16'(LT),    16'h1);
    chk({tag, "_Dig"},   16'(Dig),   16'h0);
    chk({tag, "_Frame"}, 16'(Frame), 16'h0);
  endtask

  vec_t tv [25];
  int   n;

  initial begin
    RST = 1'b1; EN = 1'b0; Data = '0; ZBLANK = 1'b0; TEST = 1'b0;

    // First frame of 16'h4321 after enable: 2 dead + 4 lit per digit
    tv[0]  = '{1'b1, 16'h4321, 4'b0000, 4'h1, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 16'h4321, 4'b0000, 4'h1, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 16'h4321, 4'b0001, 4'h1, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 16'h4321, 4'b0001, 4'h1, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 16'h4321, 4'b0001, 4'h1, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 16'h4321, 4'b0001, 4'h1, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 16'h4321, 4'b0000, 4'h2, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 16'h4321, 4'b0000, 4'h2, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 16'h4321, 4'b0010, 4'h2, 1'b1, 1'b0};
    tv[9]  = '{1'b1, 16'h4321, 4'b0010, 4'h2, 1'b1, 1'b0};
    tv[10] = '{1'b1, 16'h4321, 4'b0010, 4'h2, 1'b1, 1'b0};
    tv[11] = '{1'b1, 16'h4321, 4'b0010, 4'h2, 1'b1, 1'b0};
    tv[12] = '{1'b1, 16'h4321, 4'b0000, 4'h3, 1'b0, 1'b0};
    tv[13] = '{1'b1, 16'h4321, 4'b0000, 4'h3, 1'b0, 1'b0};
    tv[14] = '{1'b1, 16'h4321, 4'b0100, 4'h3, 1'b1, 1'b0};
    tv[15] = '{1'b1, 16'h4321, 4'b0100, 4'h3, 1'b1, 1'b0};
    tv[16] = '{1'b1, 16'h4321, 4'b0100, 4'h3, 1'b1, 1'b0};
    tv[17] = '{1'b1, 16'h4321, 4'b0100, 4'h3, 1'b1, 1'b0};
    tv[18] = '{1'b1, 16'h4321, 4'b0000, 4'h4, 1'b0, 1'b0};
    tv[19] = '{1'b1, 16'h4321, 4'b0000, 4'h4, 1'b0, 1'b0};
    tv[20] = '{1'b1, 16'h4321, 4'b1000, 4'h4, 1'b1, 1'b0};
    tv[21] = '{1'b1, 16'h4321, 4'b1000, 4'h4, 1'b1, 1'b0};
    tv[22] = '{1'b1, 16'h4321, 4'b1000, 4'h4, 1'b1, 1'b0};
    tv[23] = '{1'b1, 16'h4321, 4'b1000, 4'h4, 1'b1, 1'b0};
    tv[24] = '{1'b1, 16'h4321, 4'b0000, 4'h1, 1'b0, 1'b1};

    // Reset held three cycles
    repeat (3) step();
    chk_reset_vals("reset");

    // One idle cycle, then the table-driven first frame
    RST = 1'b0;
    step();
    for (int i = 0; i < 25; i++) begin
      EN = tv[i].en; Data = tv[i].data;
      step();
      chk($sformatf("tv%0d_Dig", i),   16'(Dig),   16'(tv[i].dig));
      chk($sformatf("tv%0d_INn", i),   16'(INn),   16'(tv[i].inn));
      chk($sformatf("tv%0d_BI", i),    16'(BI),    16'(tv[i].bi));
      chk($sformatf("tv%0d_Frame", i), 16'(Frame), 16'(tv[i].frame));
      chk($sformatf("tv%0d_LE", i),    16'(LE),    16'h0);
    end

    // Frame period in steady state
    step_until_frame(FRAME + 10, n);
    chk("frame_period", 16'(n), 16'(FRAME));

    // Leading-zero suppression on 16'h0050
    Data = 16'h0050; ZBLANK = 1'b1;
    step_until_frame(FRAME + 10, n);
    for (int i = 1; i < FRAME; i++) begin
      step();
      case (m_out.dig)
        4'b1000, 4'b0100: chk("lz_hi_BI", 16'(BI), 16'h0);
        4'b0010: begin chk("lz_d1_BI", 16'(BI), 16'h1); chk("lz_d1_INn", 16'(INn), 16'h5); end
        4'b0001: begin chk("lz_d0_BI", 16'(BI), 16'h1); chk("lz_d0_INn", 16'(INn), 16'h0); end
        default: ;
      endcase
    end
    ZBLANK = 1'b0;
    step_until_frame(FRAME + 10, n);
    for (int i = 1; i < FRAME; i++) begin
      step();
      if (m_out.dig != 4'h0) chk("nozb_BI", 16'(BI), 16'h1);
    end

    // Snapshot: Data change mid-frame waits for the next frame
    Data = 16'h1111;
    step_until_frame(FRAME + 10, n);
    step_until_dig(4'b0010, FRAME);
    Data = 16'h2222;
    n = 0;
    do begin
      step();
      n++;
      if (Frame !== 1'b1 && m_out.dig != 4'h0) chk("snap_old_INn", 16'(INn), 16'h1);
    end while (Frame !== 1'b1 && n < FRAME);
    for (int i = 1; i < FRAME; i++) begin
      step();
      if (m_out.dig != 4'h0) chk("snap_new_INn", 16'(INn), 16'h2);
    end

    // Lamp test: LT follows one cycle later, BI forced on, period unchanged
    Data = 16'h0000; ZBLANK = 1'b1; TEST = 1'b1;
    step();
    chk("lamp_LT", 16'(LT), 16'h0);
    step_until_frame(FRAME + 10, n);
    n = 0;
    do begin
      step();
      n++;
      if (m_out.dig != 4'h0) chk("lamp_BI", 16'(BI), 16'h1);
    end while (Frame !== 1'b1 && n < FRAME + 10);
    chk("lamp_period", 16'(n), 16'(FRAME));

    // Disable while digit 2 is lit, then re-enable
    TEST = 1'b0; ZBLANK = 1'b0; Data = 16'h4321;
    step_until_dig(4'b0100, 2 * FRAME);
    EN = 1'b0;
    step();
    chk("dis_Dig", 16'(Dig), 16'h0);
    chk("dis_BI", 16'(BI), 16'h0);
    chk("dis_LE", 16'(LE), 16'h1);
    chk("dis_LT", 16'(LT), 16'h1);
    chk("dis_Frame", 16'(Frame), 16'h0);
    EN = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (Dig == 4'h0 && n < FRAME);
    chk("reen_latency", 16'(n), 16'(DEAD + 1));
    chk("reen_Dig", 16'(Dig), 16'h1);

    // EN drop on the same edge as a frame end: no Frame pulse
    n = 0;
    while (m_pos != FRAME - 1 && n < 2 * FRAME) begin
      step();
      n++;
    end
    if (m_pos != FRAME - 1) timeout("frame_end_wait");
    EN = 1'b0;
    step();
    chk("enfall_Frame", 16'(Frame), 16'h0);
    chk("enfall_Dig", 16'(Dig), 16'h0);
    EN = 1'b1;

    // Reset in the middle of a lit digit
    step_until_dig(4'b0001, 2 * FRAME);
    step();
    RST = 1'b1;
    step();
    chk_reset_vals("midrst");
    RST = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
